// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for common-anode 7-segment digits on a shared bus.
// A shadow register is copied to the display register only at frame boundaries, so a frame never tears.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned TICKS_ON   = 1000,
  parameter int unsigned TICKS_GAP  = 16
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   value_in,
  input  logic                      blank_lz,
  output logic [7:0]                seg_out,
  output logic [NUM_DIGITS-1:0]     dig_sel,
  output logic                      frame_done
);

  localparam int unsigned VAL_W    = 4 * NUM_DIGITS;
  localparam int unsigned IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned MAX_T    = (TICKS_ON > TICKS_GAP) ? TICKS_ON : TICKS_GAP;
  localparam int unsigned CNT_W    = (MAX_T > 1) ? $clog2(MAX_T) : 1;
  localparam int unsigned ON_LAST  = TICKS_ON - 1;
  localparam int unsigned GAP_LAST = (TICKS_GAP > 0) ? TICKS_GAP - 1 : 0;
  localparam int unsigned IDX_LAST = NUM_DIGITS - 1;

  typedef enum logic [1:0] {
    ST_OFF = 2'd0,
    ST_ON  = 2'd1,
    ST_GAP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wrap_q, wrap_d;
  logic [VAL_W-1:0]  shadow_q, shadow_d;
  logic [VAL_W-1:0]  display_q, display_d;
  logic [7:0]        seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic              frame_done_q, frame_done_d;

  logic              slot_end;
  logic              lit;
  logic [VAL_W-1:0]  upper;

  // Active-low {g,f,e,d,c,b,a} patterns for one hex nibble.
  function automatic logic [6:0] dec7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      wrap_q       <= 1'b0;
      shadow_q     <= '0;
      display_q    <= '0;
      seg_q        <= 8'hFF;
      dig_q        <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      wrap_q       <= wrap_d;
      shadow_q     <= shadow_d;
      display_q    <= display_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Slot sequencing: ON for TICKS_ON, optional GAP, then advance the digit index.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q + CNT_W'(1);
    wrap_d   = 1'b0;
    slot_end = 1'b0;
    if (!enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_ON;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_ON: begin
          if (cnt_q == CNT_W'(ON_LAST)) begin
            cnt_d = '0;
            if (TICKS_GAP == 0) begin
              slot_end = 1'b1;
            end else begin
              state_d = ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (cnt_q == CNT_W'(GAP_LAST)) begin
            cnt_d    = '0;
            state_d  = ST_ON;
            slot_end = 1'b1;
          end
        end
        default: begin
          state_d = ST_OFF;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
      if (slot_end) begin
        if (idx_q == IDX_W'(IDX_LAST)) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end
  end

  // Buffering and registered pin drive; pins reflect the state held during the previous cycle.
  always_comb begin
    shadow_d  = load ? value_in : shadow_q;
    display_d = display_q;
    if (state_q == ST_OFF || wrap_d) begin
      display_d = load ? value_in : shadow_q;
    end
    upper = display_q >> {idx_q, 2'b00};
    lit   = enable && (state_q == ST_ON) &&
            !(blank_lz && (idx_q != '0) && (upper == '0));
    seg_d = lit ? {1'b1, dec7(upper[3:0])} : 8'hFF;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      dig_d[i] = !(lit && (idx_q == IDX_W'(i)));
    end
    frame_done_d = enable && wrap_q;
  end

  assign seg_out    = seg_q;
  assign dig_sel    = dig_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl: two instances (with and without inter-digit gap) checked against
// a slot-arithmetic reference model plus directed values from the display patterns.
module tb_seg7_scan_ctrl;

  localparam int N  = 4;
  localparam int ON = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] value_in = 16'h0;

  logic [7:0]  seg_a, seg_b;
  logic [3:0]  dig_a, dig_b;
  logic        fd_a, fd_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICKS_ON(4), .TICKS_GAP(2)) dut_a (
    .clk(clk), .clr(clr), .enable(enable), .load(load), .value_in(value_in),
    .blank_lz(blank_lz), .seg_out(seg_a), .dig_sel(dig_a), .frame_done(fd_a)
  );

  seg7_scan_ctrl #(.NUM_DIGITS(4), .TICKS_ON(4), .TICKS_GAP(0)) dut_b (
    .clk(clk), .clr(clr), .enable(enable), .load(load), .value_in(value_in),
    .blank_lz(blank_lz), .seg_out(seg_b), .dig_sel(dig_b), .frame_done(fd_b)
  );

  // Reference model: scan position counted in cycles; digit and lit/dark derived by division.
  logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int          gap_m [2] = '{2, 0};
  bit          run_m [2];
  int          pos_m [2];
  bit          wrap_m [2];
  logic [15:0] disp_m [2];
  logic [15:0] shadow_m = 16'h0;
  logic [7:0]  exp_seg [2];
  logic [3:0]  exp_dig [2];
  logic        exp_fd [2];
  int          cyc_n = 0;

  int          m_slot, m_d;
  bit          m_lit;
  logic [15:0] m_up, m_ld;

  always @(posedge clk) begin
    cyc_n++;
    m_ld = load ? value_in : shadow_m;
    for (int m = 0; m < 2; m++) begin
      m_slot = ON + gap_m[m];
      m_d    = (pos_m[m] / m_slot) % N;
      m_up   = disp_m[m] >> (4 * m_d);
      m_lit  = enable && run_m[m] && ((pos_m[m] % m_slot) < ON) &&
               !(blank_lz && (m_d > 0) && (m_up == 16'h0));
      if (clr) begin
        exp_seg[m] = 8'hFF; exp_dig[m] = 4'hF; exp_fd[m] = 1'b0;
        run_m[m] = 1'b0; pos_m[m] = 0; wrap_m[m] = 1'b0; disp_m[m] = 16'h0;
      end else begin
        exp_seg[m] = m_lit ? seg_tbl[m_up[3:0]] : 8'hFF;
        exp_dig[m] = m_lit ? ~(4'b0001 << m_d) : 4'hF;
        exp_fd[m]  = enable && wrap_m[m];
        if (!enable) begin
          if (!run_m[m]) disp_m[m] = m_ld;
          run_m[m] = 1'b0; pos_m[m] = 0; wrap_m[m] = 1'b0;
        end else if (!run_m[m]) begin
          disp_m[m] = m_ld;
          run_m[m] = 1'b1; pos_m[m] = 0; wrap_m[m] = 1'b0;
        end else begin
          pos_m[m]++;
          wrap_m[m] = (pos_m[m] % (m_slot * N)) == 0;
          if (wrap_m[m]) disp_m[m] = m_ld;
        end
      end
    end
    shadow_m = clr ? 16'h0 : m_ld;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clr = 1'b1; enable = 1'b0; load = 1'b0;
    cyc(); cyc();
    tests++; if (seg_a !== 8'hFF) begin fails++; $display("FAIL reset_seg_a got %h want ff", seg_a); end
    tests++; if (dig_a !== 4'hF)  begin fails++; $display("FAIL reset_dig_a got %b want 1111", dig_a); end
    tests++; if (fd_a !== 1'b0)   begin fails++; $display("FAIL reset_fd_a got %b want 0", fd_a); end
    tests++; if ({seg_b, dig_b, fd_b} !== {8'hFF, 4'hF, 1'b0}) begin
      fails++; $display("FAIL reset_b got %h/%b/%b want ff/1111/0", seg_b, dig_b, fd_b);
    end
    clr = 1'b0;
  endtask

  task automatic test_basic_scan();
    int last_a = 0, last_b = 0;
    logic [7:0] want;
    blank_lz = 1'b0;
    load = 1'b1; value_in = 16'h1234; cyc(); load = 1'b0;
    enable = 1'b1;
    for (int i = 0; i < 60; i++) begin
      cyc();
      tests++; if ({seg_a, dig_a, fd_a} !== {exp_seg[0], exp_dig[0], exp_fd[0]}) begin
        fails++; $display("FAIL basic_a cyc %0d got %h/%b/%b want %h/%b/%b", i, seg_a, dig_a, fd_a, exp_seg[0], exp_dig[0], exp_fd[0]);
      end
      tests++; if ({seg_b, dig_b, fd_b} !== {exp_seg[1], exp_dig[1], exp_fd[1]}) begin
        fails++; $display("FAIL basic_b cyc %0d got %h/%b/%b want %h/%b/%b", i, seg_b, dig_b, fd_b, exp_seg[1], exp_dig[1], exp_fd[1]);
      end
      case (dig_a)
        4'b1110: want = 8'h99;
        4'b1101: want = 8'hB0;
        4'b1011: want = 8'hA4;
        4'b0111: want = 8'hF9;
        default: want = 8'hFF;
      endcase
      tests++; if (seg_a !== want) begin fails++; $display("FAIL basic_digit got seg %h with dig %b want %h", seg_a, dig_a, want); end
      if (fd_a === 1'b1) begin
        if (last_a != 0) begin
          tests++; if (cyc_n - last_a != 24) begin fails++; $display("FAIL frame_len_a got %0d want 24", cyc_n - last_a); end
        end
        last_a = cyc_n;
      end
      if (fd_b === 1'b1) begin
        if (last_b != 0) begin
          tests++; if (cyc_n - last_b != 16) begin fails++; $display("FAIL frame_len_b got %0d want 16", cyc_n - last_b); end
        end
        last_b = cyc_n;
      end
    end
    tests++; if (last_a == 0 || last_b == 0) begin fails++; $display("FAIL frame_done_seen got a=%0d b=%0d want nonzero", last_a, last_b); end
  endtask

  task automatic test_blank();
    logic [15:0] vals [3] = '{16'h0005, 16'h0000, 16'h0500};
    blank_lz = 1'b1;
    for (int v = 0; v < 3; v++) begin
      load = 1'b1; value_in = vals[v]; cyc(); load = 1'b0;
      for (int i = 0; i < 55; i++) begin
        cyc();
        tests++; if ({seg_a, dig_a, fd_a} !== {exp_seg[0], exp_dig[0], exp_fd[0]}) begin
          fails++; $display("FAIL blank_a v%0d cyc %0d got %h/%b/%b want %h/%b/%b", v, i, seg_a, dig_a, fd_a, exp_seg[0], exp_dig[0], exp_fd[0]);
        end
        tests++; if ({seg_b, dig_b, fd_b} !== {exp_seg[1], exp_dig[1], exp_fd[1]}) begin
          fails++; $display("FAIL blank_b v%0d cyc %0d got %h/%b/%b want %h/%b/%b", v, i, seg_b, dig_b, fd_b, exp_seg[1], exp_dig[1], exp_fd[1]);
        end
        if (i > 30 && v == 2) begin
          tests++; if (dig_a == 4'b0111 || (dig_a == 4'b1101 && seg_a !== 8'hC0)) begin
            fails++; $display("FAIL blank_0500 got seg %h dig %b want digit3 dark, digit1 c0", seg_a, dig_a);
          end
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_tear_free();
    int  budget = 0;
    bit  seen_fd = 1'b0;
    load = 1'b1; value_in = 16'h1234; cyc(); load = 1'b0;
    repeat (30) cyc();
    while (dig_a !== 4'b1101 && budget < 40) begin cyc(); budget++; end
    tests++; if (budget >= 40) begin fails++; $display("FAIL tear_wait got timeout want digit1 lit"); end
    load = 1'b1; value_in = 16'hABCD; cyc(); load = 1'b0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (fd_a === 1'b1) seen_fd = 1'b1;
      tests++; if ({seg_a, dig_a, fd_a} !== {exp_seg[0], exp_dig[0], exp_fd[0]}) begin
        fails++; $display("FAIL tear_a cyc %0d got %h/%b/%b want %h/%b/%b", i, seg_a, dig_a, fd_a, exp_seg[0], exp_dig[0], exp_fd[0]);
      end
      if (!seen_fd && dig_a == 4'b1011) begin
        tests++; if (seg_a !== 8'hA4) begin fails++; $display("FAIL tear_old_d2 got %h want a4", seg_a); end
      end
      if (!seen_fd && dig_a == 4'b0111) begin
        tests++; if (seg_a !== 8'hF9) begin fails++; $display("FAIL tear_old_d3 got %h want f9", seg_a); end
      end
      if (seen_fd && dig_a == 4'b1110) begin
        tests++; if (seg_a !== 8'hA1) begin fails++; $display("FAIL tear_new_d0 got %h want a1", seg_a); end
      end
      if (seen_fd && dig_a == 4'b0111) begin
        tests++; if (seg_a !== 8'h88) begin fails++; $display("FAIL tear_new_d3 got %h want 88", seg_a); end
      end
    end
  endtask

  task automatic test_wrap_load();
    int budget = 0;
    while (!(run_m[0] && ((pos_m[0] + 1) % 24 == 0)) && budget < 40) begin cyc(); budget++; end
    tests++; if (budget >= 40) begin fails++; $display("FAIL wrap_wait got timeout want wrap edge"); end
    load = 1'b1; value_in = 16'h00FF; cyc(); load = 1'b0;
    cyc();
    tests++; if ({seg_a, dig_a, fd_a} !== {8'h8E, 4'b1110, 1'b1}) begin
      fails++; $display("FAIL wrap_load got %h/%b/%b want 8e/1110/1", seg_a, dig_a, fd_a);
    end
    for (int i = 0; i < 30; i++) begin
      cyc();
      tests++; if ({seg_b, dig_b, fd_b} !== {exp_seg[1], exp_dig[1], exp_fd[1]}) begin
        fails++; $display("FAIL wrap_b cyc %0d got %h/%b/%b want %h/%b/%b", i, seg_b, dig_b, fd_b, exp_seg[1], exp_dig[1], exp_fd[1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int budget = 0;
    while (dig_a !== 4'b1011 && budget < 40) begin cyc(); budget++; end
    tests++; if (budget >= 40) begin fails++; $display("FAIL rstmid_wait got timeout want digit2 lit"); end
    clr = 1'b1; cyc(); clr = 1'b0;
    tests++; if ({seg_a, dig_a, fd_a} !== {8'hFF, 4'hF, 1'b0}) begin
      fails++; $display("FAIL rstmid_dark got %h/%b/%b want ff/1111/0", seg_a, dig_a, fd_a);
    end
    budget = 0;
    while (dig_a === 4'hF && budget < 10) begin
      cyc(); budget++;
      tests++; if ({seg_a, dig_a, fd_a} !== {exp_seg[0], exp_dig[0], exp_fd[0]}) begin
        fails++; $display("FAIL rstmid_a got %h/%b/%b want %h/%b/%b", seg_a, dig_a, fd_a, exp_seg[0], exp_dig[0], exp_fd[0]);
      end
    end
    tests++; if ({seg_a, dig_a} !== {8'hC0, 4'b1110}) begin
      fails++; $display("FAIL rstmid_restart got %h/%b want c0/1110", seg_a, dig_a);
    end
  endtask

  task automatic test_enable_drop();
    int  budget = 0;
    bit  b_lit = 1'b0;
    load = 1'b1; value_in = 16'h1234; cyc(); load = 1'b0;
    repeat (8) cyc();
    while (dig_a === 4'hF && budget < 20) begin cyc(); budget++; end
    enable = 1'b0; cyc();
    tests++; if ({seg_a, dig_a, fd_a, seg_b, dig_b, fd_b} !== {8'hFF, 4'hF, 1'b0, 8'hFF, 4'hF, 1'b0}) begin
      fails++; $display("FAIL endrop_dark got %h/%b/%b %h/%b/%b want ff/1111/0 both", seg_a, dig_a, fd_a, seg_b, dig_b, fd_b);
    end
    repeat (3) cyc();
    enable = 1'b1;
    budget = 0;
    while (dig_a === 4'hF && budget < 10) begin cyc(); budget++; end
    tests++; if ({seg_a, dig_a} !== {8'h99, 4'b1110}) begin
      fails++; $display("FAIL endrop_restart got %h/%b want 99/1110", seg_a, dig_a);
    end
    for (int i = 0; i < 40; i++) begin
      if (dig_b !== 4'hF) b_lit = 1'b1;
      if (b_lit) begin
        tests++; if (dig_b === 4'hF) begin fails++; $display("FAIL nogap_dark cyc %0d got dig %b want lit", i, dig_b); end
      end
      cyc();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom % 6) == 0;
      value_in = 16'($urandom);
      if (($urandom % 3) == 0) value_in = value_in & 16'h00FF;
      blank_lz = ($urandom % 3) == 0;
      enable   = ($urandom % 40) != 0;
      clr      = ($urandom % 250) == 0;
      cyc();
      tests++; if ({seg_a, dig_a, fd_a} !== {exp_seg[0], exp_dig[0], exp_fd[0]}) begin
        fails++; $display("FAIL rand_a cyc %0d got %h/%b/%b want %h/%b/%b", i, seg_a, dig_a, fd_a, exp_seg[0], exp_dig[0], exp_fd[0]);
      end
      tests++; if ({seg_b, dig_b, fd_b} !== {exp_seg[1], exp_dig[1], exp_fd[1]}) begin
        fails++; $display("FAIL rand_b cyc %0d got %h/%b/%b want %h/%b/%b", i, seg_b, dig_b, fd_b, exp_seg[1], exp_dig[1], exp_fd[1]);
      end
    end
    clr = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_scan();
    test_blank();
    test_tear_free();
    test_wrap_load();
    test_reset_mid();
    test_enable_drop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

endmodule
